multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle FSM control unit for the 16-bit, 4-bit-opcode ISA: sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
//  Drives datapath strobes and handles a ready/request memory handshake with a wait-state watchdog.
//  Counts retired instructions. Sits between the instruction register / ALU flags and the shared-memory datapath.
// PARAMETERS
//  ALUOP_W   4   width of alu_op (encodings: ADD=0 SUB=1 AND=2 OR=3 SLL=4 LUI=5)
//  MAX_WAIT  15  max cycles a memory request may stay unacknowledged before FAULT (1..255)
//  CNT_W     16  width of retired-instruction counter
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  opcode     in   4        IR[15:12]; valid from DECODE onward
//  fn         in   3        IR function field (R-type)
//  alu_zero   in   1        ALU result == 0 (EXEC only)
//  alu_neg    in   1        ALU result sign bit (EXEC only)
//  mem_ready  in   1        memory acknowledge for the current mem_req
//  mem_req    out  1        memory access request, held until mem_ready
//  mem_write  out  1        1: write (store), 0: read; qualified by mem_req
//  mem_addr_sel out 1       0: PC, 1: ALU result
//  ir_we      out  1        latch instruction word
//  pc_we      out  1        update PC
//  pc_src     out  2        00 PC+1, 01 branch target, 10 jump target, 11 rs (jr)
//  reg_we     out  1        register-file write
//  wb_reg     out  1        0: rt, 1: rd
//  wb_src     out  2        00 mem data, 01 ALU, 10 PC (link)
//  alu_src_a  out  1        0: rs, 1: rt
//  alu_src_b  out  1        1: shifted/sign-extended immediate
//  ltype      out  1        1: upper/lower 8-bit immediate form
//  alu_op     out  ALUOP_W  ALU operation
//  state      out  3        FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 FAULT=6
//  retire     out  1        one-cycle pulse on instruction completion
//  instret    out  CNT_W    retired-instruction count, wraps to 0 after all-ones
//  halted     out  1        high in HALT
//  fault      out  1        high in FAULT
// BEHAVIOUR
//  Reset: state=FETCH, wait_cnt=0, instret=0. While rst is high, all strobes, retire, halted and fault are 0.
//  Outputs are combinational from state, opcode, fn and flags. alu_op is 0 when unused.
//  FETCH: mem_req=1, mem_addr_sel=0. On mem_ready: ir_we=1, pc_we=1, pc_src=00, go to DECODE.
//  DECODE by opcode:
//    0 R-type: fn 0-3 -> EXEC. fn 4 (jr): pc_we, pc_src=11, retire -> FETCH. fn 7 -> HALT.
//      Other fn values are no-ops: retire -> FETCH.
//    1 addi, 2 subi, 3 lui, 4 slli, 5 load, 6 store, 9 beq, 10 blt -> EXEC.
//    7 j: pc_we, pc_src=10, retire -> FETCH.
//    8 jl: pc_we, pc_src=10, reg_we, wb_reg=0, wb_src=10, retire -> FETCH.
//    11-15 undefined: treated as a no-op, retire -> FETCH.
//  EXEC: ALU controls per opcode (same encoding as the single-cycle unit):
//    R: op by fn. addi/subi: a=1, ltype=1, b=0. lui: a=1, ltype=1, b=1, LUI. slli: b=1, SLL.
//    load/store: b=1, ADD. beq/blt: SUB.
//    Arithmetic ops -> WB. load/store -> MEM.
//    beq: pc_we=alu_zero. blt: pc_we=alu_neg. Both with pc_src=01, retire -> FETCH.
//  MEM: mem_req=1, mem_addr_sel=1, mem_write=(store). On mem_ready: store retires -> FETCH; load -> WB.
//  WB: reg_we=1, retire -> FETCH. R-type: wb_reg=1, wb_src=01. imm ops: wb_reg=0, wb_src=01. load: wb_reg=0, wb_src=00.
//  Watchdog: wait_cnt clears on entering FETCH/MEM and increments each cycle mem_req is high without mem_ready.
//    mem_ready arriving in the cycle wait_cnt==MAX_WAIT-1 is accepted. Otherwise at wait_cnt==MAX_WAIT -> FAULT.
//  HALT and FAULT are absorbing until rst. No strobes are asserted. halted/fault stay high.
//  retire increments instret on the same clock edge (HALT instruction itself retires on entry to HALT).
//  rst mid-access drops mem_req asynchronously. The aborted instruction is not counted.
// TESTING
//  Reset, then addi with mem_ready on the 1st request -> states 0,1,2,4,0. reg_we in WB only. instret=1.
//  load with FETCH ready after 3 waits and MEM ready after 2 -> mem_req held 4+3 cycles. wb_src=00 in WB.
//  beq with alu_zero=1, then with alu_zero=0 -> pc_we=1/pc_src=01 vs pc_we=0. Both retire after 3 cycles.
//  jl -> DECODE asserts pc_we, pc_src=10, reg_we, wb_src=10. Returns to FETCH. No EXEC visit.
//  mem_ready withheld (MAX_WAIT=15) -> fault=1 and state=6 after 15 waiting cycles. Held until rst.
//  R-type fn=7 -> halted=1, instret+1. Further mem_ready pulses are ignored. rst -> state=0, instret=0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the control unit (master) and shared memory (slave).
interface multicycle_control_unit_if;
    logic mem_req;
    logic mem_write;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory wait watchdog
// and a retired-instruction counter.
module multicycle_control_unit #(
    parameter int unsigned ALUOP_W  = 4,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_unit_if.master  mem,
    input  logic [3:0]                 opcode,
    input  logic [2:0]                 fn,
    input  logic                       alu_zero,
    input  logic                       alu_neg,
    output logic                       ir_we,
    output logic                       pc_we,
    output logic [1:0]                 pc_src,
    output logic                       reg_we,
    output logic                       wb_reg,
    output logic [1:0]                 wb_src,
    output logic                       alu_src_a,
    output logic                       alu_src_b,
    output logic                       ltype,
    output logic [ALUOP_W-1:0]         alu_op,
    output logic [2:0]                 state,
    output logic                       retire,
    output logic [CNT_W-1:0]           instret,
    output logic                       halted,
    output logic                       fault
);
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StFault  = 3'd6
    } state_e;

    localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AluSll = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] AluLui = ALUOP_W'(5);
    localparam logic [7:0]         WaitLast = 8'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] instret_q;
    logic             req, wr, addr_sel;

    assign mem.mem_req      = req;
    assign mem.mem_write    = wr;
    assign mem.mem_addr_sel = addr_sel;
    assign state            = state_q;
    assign instret          = instret_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req        = 1'b0;
        wr         = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        reg_we     = 1'b0;
        wb_reg     = 1'b0;
        wb_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        ltype      = 1'b0;
        alu_op     = AluAdd;
        retire     = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        // Everything is gated by rst so an in-flight request drops asynchronously.
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    req = 1'b1;
                    if (mem.mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = StDecode;
                    end else if (wait_cnt_q == WaitLast) begin
                        state_d = StFault;
                    end
                end
                StDecode: begin
                    case (opcode)
                        4'd0: begin
                            case (fn)
                                3'd0, 3'd1, 3'd2, 3'd3: state_d = StExec;
                                3'd4: begin
                                    pc_we   = 1'b1;
                                    pc_src  = 2'b11;
                                    retire  = 1'b1;
                                    state_d = StFetch;
                                end
                                3'd7: begin
                                    retire  = 1'b1;
                                    state_d = StHalt;
                                end
                                default: begin
                                    retire  = 1'b1;
                                    state_d = StFetch;
                                end
                            endcase
                        end
                        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10: state_d = StExec;
                        4'd7, 4'd8: begin
                            pc_we   = 1'b1;
                            pc_src  = 2'b10;
                            retire  = 1'b1;
                            state_d = StFetch;
                            if (opcode == 4'd8) begin
                                reg_we = 1'b1;
                                wb_src = 2'b10;
                            end
                        end
                        default: begin
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                    endcase
                end
                StExec: begin
                    state_d = StWb;
                    case (opcode)
                        4'd0: alu_op = ALUOP_W'(fn);
                        4'd1, 4'd2: begin
                            alu_src_a = 1'b1;
                            ltype     = 1'b1;
                            alu_op    = (opcode == 4'd2) ? AluSub : AluAdd;
                        end
                        4'd3: begin
                            alu_src_a = 1'b1;
                            ltype     = 1'b1;
                            alu_src_b = 1'b1;
                            alu_op    = AluLui;
                        end
                        4'd4: begin
                            alu_src_b = 1'b1;
                            alu_op    = AluSll;
                        end
                        4'd5, 4'd6: begin
                            alu_src_b = 1'b1;
                            state_d   = StMem;
                        end
                        4'd9, 4'd10: begin
                            alu_op  = AluSub;
                            pc_we   = (opcode == 4'd9) ? alu_zero : alu_neg;
                            pc_src  = 2'b01;
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                        default: begin
                            retire  = 1'b1;
                            state_d = StFetch;
                        end
                    endcase
                end
                StMem: begin
                    req      = 1'b1;
                    addr_sel = 1'b1;
                    wr       = (opcode == 4'd6);
                    if (mem.mem_ready) begin
                        if (opcode == 4'd6) begin
                            retire  = 1'b1;
                            state_d = StFetch;
                        end else begin
                            state_d = StWb;
                        end
                    end else if (wait_cnt_q == WaitLast) begin
                        state_d = StFault;
                    end
                end
                StWb: begin
                    reg_we  = 1'b1;
                    retire  = 1'b1;
                    state_d = StFetch;
                    wb_reg  = (opcode == 4'd0);
                    wb_src  = (opcode == 4'd5) ? 2'b00 : 2'b01;
                end
                StHalt:  halted = 1'b1;
                StFault: fault  = 1'b1;
                default: state_d = StFault;
            endcase
            if (state_d != state_q) begin
                wait_cnt_d = 8'd0;
            end else if (req && !mem.mem_ready) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            wait_cnt_q <= 8'd0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (retire) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: table of instructions with expected traces, scoreboard popped on retire.
module tb_multicycle_control_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic [2:0]  fn;
    logic        alu_zero, alu_neg;
    logic        ir_we, pc_we, reg_we, wb_reg, alu_src_a, alu_src_b, ltype;
    logic [1:0]  pc_src, wb_src;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic        retire, halted, fault;
    logic [15:0] instret;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(
        .ALUOP_W  (4),
        .MAX_WAIT (15),
        .CNT_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (bus),
        .opcode    (opcode),
        .fn        (fn),
        .alu_zero  (alu_zero),
        .alu_neg   (alu_neg),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .reg_we    (reg_we),
        .wb_reg    (wb_reg),
        .wb_src    (wb_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .ltype     (ltype),
        .alu_op    (alu_op),
        .state     (state),
        .retire    (retire),
        .instret   (instret),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  fn;
        logic        z, n;
        int          fw, mw;     // wait cycles before mem_ready in FETCH / MEM
        logic [14:0] path;       // distinct states visited, 3 bits each, 7 = unused
        int          cyc, nreg, npc, nreq, nwr;
        logic [1:0]  wb_src;
        logic        wb_reg;
        logic [1:0]  pc_src;
        logic [3:0]  aluop;
        logic        srcb;
    } vec_t;

    vec_t vecs[19];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_instret = 0;

    function automatic logic [14:0] p(int a, int b, int c, int d, int e);
        return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic vec_t mkv(int op, int f, int z, int n, int fw, int mw, logic [14:0] pth,
                                 int cyc, int nreg, int npc, int nreq, int nwr, int wbs,
                                 int wbr, int pcs, int aop, int sb_);
        vec_t v;
        v.op = 4'(op); v.fn = 3'(f); v.z = 1'(z); v.n = 1'(n); v.fw = fw; v.mw = mw;
        v.path = pth; v.cyc = cyc; v.nreg = nreg; v.npc = npc; v.nreq = nreq; v.nwr = nwr;
        v.wb_src = 2'(wbs); v.wb_reg = 1'(wbr); v.pc_src = 2'(pcs); v.aluop = 4'(aop);
        v.srcb = 1'(sb_);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t        v, e;
        logic [14:0] path;
        int          np, last, nreg, npc, nreq, nwr, phase, w, lim, ncyc;
        logic [1:0]  c_wbs, c_pcs;
        logic        c_wbr, c_srcb, got;
        logic [3:0]  c_aop;
        v = vecs[idx];
        sb.push_back(v);
        path = 15'h7fff; np = 0; last = 7;
        nreg = 0; npc = 0; nreq = 0; nwr = 0; phase = 0; w = 0; ncyc = 0;
        c_wbs = 0; c_pcs = 0; c_wbr = 0; c_srcb = 0; c_aop = 0; got = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            opcode = v.op; fn = v.fn; alu_zero = v.z; alu_neg = v.n; bus.mem_ready = 1'b0;
            #1;
            if (bus.mem_req) begin
                lim = (phase == 0) ? v.fw : v.mw;
                if (w == lim) begin
                    bus.mem_ready = 1'b1;
                    phase++;
                    w = 0;
                end else begin
                    w++;
                end
            end
            #1;
            if (int'(state) != last && np < 5) begin
                path[3*np +: 3] = state;
                np++;
                last = int'(state);
            end
            if (reg_we) begin nreg++; c_wbs = wb_src; c_wbr = wb_reg; end
            if (pc_we) begin npc++; c_pcs = pc_src; end
            if (bus.mem_req) nreq++;
            if (bus.mem_req && bus.mem_write) nwr++;
            if (state == 3'd2) begin c_aop = alu_op; c_srcb = alu_src_b; end
            if (retire) begin got = 1'b1; ncyc = cyc; end
            @(posedge clk);
            #1;
            if (got) break;
        end
        bus.mem_ready = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            chk($sformatf("v%0d_retire_timeout", idx), 0, 1);
        end else begin
            exp_instret++;
            chk($sformatf("v%0d_path", idx), int'(path), int'(e.path));
            chk($sformatf("v%0d_cycles", idx), ncyc, e.cyc);
            chk($sformatf("v%0d_reg_we_cnt", idx), nreg, e.nreg);
            chk($sformatf("v%0d_pc_we_cnt", idx), npc, e.npc);
            chk($sformatf("v%0d_mem_req_cnt", idx), nreq, e.nreq);
            chk($sformatf("v%0d_mem_write_cnt", idx), nwr, e.nwr);
            chk($sformatf("v%0d_wb_src", idx), int'(c_wbs), int'(e.wb_src));
            chk($sformatf("v%0d_wb_reg", idx), int'(c_wbr), int'(e.wb_reg));
            chk($sformatf("v%0d_pc_src", idx), int'(c_pcs), int'(e.pc_src));
            chk($sformatf("v%0d_alu_op", idx), int'(c_aop), int'(e.aluop));
            chk($sformatf("v%0d_alu_src_b", idx), int'(c_srcb), int'(e.srcb));
        end
        chk($sformatf("v%0d_instret", idx), int'(instret), exp_instret);
        chk($sformatf("v%0d_state_fetch", idx), int'(state), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        //                 op fn z n fw mw path               cyc reg pc req wr wbs wbr pcs aop sb
        vecs[0]  = mkv(1,  0, 0, 0, 0,  0,  p(0, 1, 2, 4, 7), 4,  1, 1, 1,  0, 1, 0, 0, 0, 0);
        vecs[1]  = mkv(5,  0, 0, 0, 3,  2,  p(0, 1, 2, 3, 4), 10, 1, 1, 7,  0, 0, 0, 0, 0, 1);
        vecs[2]  = mkv(9,  0, 1, 0, 0,  0,  p(0, 1, 2, 7, 7), 3,  0, 2, 1,  0, 0, 0, 1, 1, 0);
        vecs[3]  = mkv(9,  0, 0, 0, 0,  0,  p(0, 1, 2, 7, 7), 3,  0, 1, 1,  0, 0, 0, 0, 1, 0);
        vecs[4]  = mkv(10, 0, 0, 1, 0,  0,  p(0, 1, 2, 7, 7), 3,  0, 2, 1,  0, 0, 0, 1, 1, 0);
        vecs[5]  = mkv(10, 0, 1, 0, 0,  0,  p(0, 1, 2, 7, 7), 3,  0, 1, 1,  0, 0, 0, 0, 1, 0);
        vecs[6]  = mkv(8,  0, 0, 0, 0,  0,  p(0, 1, 7, 7, 7), 2,  1, 2, 1,  0, 2, 0, 2, 0, 0);
        vecs[7]  = mkv(7,  0, 0, 0, 0,  0,  p(0, 1, 7, 7, 7), 2,  0, 2, 1,  0, 0, 0, 2, 0, 0);
        vecs[8]  = mkv(0,  1, 0, 0, 0,  0,  p(0, 1, 2, 4, 7), 4,  1, 1, 1,  0, 1, 1, 0, 1, 0);
        vecs[9]  = mkv(0,  3, 0, 0, 0,  0,  p(0, 1, 2, 4, 7), 4,  1, 1, 1,  0, 1, 1, 0, 3, 0);
        vecs[10] = mkv(0,  4, 0, 0, 0,  0,  p(0, 1, 7, 7, 7), 2,  0, 2, 1,  0, 0, 0, 3, 0, 0);
        vecs[11] = mkv(6,  0, 0, 0, 1,  0,  p(0, 1, 2, 3, 7), 5,  0, 1, 3,  1, 0, 0, 0, 0, 1);
        vecs[12] = mkv(3,  0, 0, 0, 0,  0,  p(0, 1, 2, 4, 7), 4,  1, 1, 1,  0, 1, 0, 0, 5, 1);
        vecs[13] = mkv(4,  0, 0, 0, 0,  0,  p(0, 1, 2, 4, 7), 4,  1, 1, 1,  0, 1, 0, 0, 4, 1);
        vecs[14] = mkv(12, 0, 0, 0, 0,  0,  p(0, 1, 7, 7, 7), 2,  0, 1, 1,  0, 0, 0, 0, 0, 0);
        vecs[15] = mkv(2,  0, 0, 0, 0,  0,  p(0, 1, 2, 4, 7), 4,  1, 1, 1,  0, 1, 0, 0, 1, 0);
        vecs[16] = mkv(0,  5, 0, 0, 0,  0,  p(0, 1, 7, 7, 7), 2,  0, 1, 1,  0, 0, 0, 0, 0, 0);
        vecs[17] = mkv(1,  0, 0, 0, 14, 0,  p(0, 1, 2, 4, 7), 18, 1, 1, 15, 0, 1, 0, 0, 0, 0);
        vecs[18] = mkv(5,  0, 0, 0, 0,  14, p(0, 1, 2, 3, 4), 19, 1, 1, 16, 0, 0, 0, 0, 0, 1);

        rst = 1'b1; opcode = 4'd0; fn = 3'd0; alu_zero = 1'b0; alu_neg = 1'b0;
        bus.mem_ready = 1'b1;
        #3;
        chk("rst_state", int'(state), 0);
        chk("rst_mem_req", int'(bus.mem_req), 0);
        chk("rst_ir_we", int'(ir_we), 0);
        chk("rst_retire", int'(retire), 0);
        chk("rst_halted_fault", int'({halted, fault}), 0);
        chk("rst_instret", int'(instret), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mem_ready = 1'b0;

        for (int i = 0; i < 19; i++) run_vec(i);

        // HALT: retires on entry, then ignores memory.
        opcode = 4'd0; fn = 3'd7; bus.mem_ready = 1'b1;
        #2;
        chk("halt_fetch_ir_we", int'(ir_we), 1);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #1;
        chk("halt_decode_retire", int'(retire), 1);
        @(posedge clk);
        #1;
        exp_instret++;
        chk("halt_state", int'(state), 5);
        chk("halt_halted", int'(halted), 1);
        chk("halt_instret", int'(instret), exp_instret);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            chk("halt_absorb_state", int'(state), 5);
            chk("halt_no_strobes", int'({bus.mem_req, pc_we, ir_we, reg_we, retire}), 0);
            @(posedge clk);
            #1;
        end
        chk("halt_instret_hold", int'(instret), exp_instret);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("halt_rst_state", int'(state), 0);
        chk("halt_rst_instret", int'(instret), 0);
        chk("halt_rst_halted", int'(halted), 0);
        exp_instret = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Watchdog: mem_ready withheld in FETCH.
        opcode = 4'd1; fn = 3'd0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (state == 3'd6) break;
            if (bus.mem_req) n++;
            @(posedge clk);
            #1;
        end
        chk("wd_wait_cycles", n, 15);
        chk("wd_state", int'(state), 6);
        chk("wd_fault", int'(fault), 1);
        chk("wd_mem_req", int'(bus.mem_req), 0);
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("wd_absorb", int'({state, fault}), 13);
        end
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("wd_rst_fault", int'(fault), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset drops an in-flight request.
        #1;
        chk("abort_req_before", int'(bus.mem_req), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_req_after", int'(bus.mem_req), 0);
        chk("abort_instret", int'(instret), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
